mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-port round-robin arbiter and sequencer for the shared single-port word memory.
//  Port 0 is instruction fetch; port 1 is load/store.
//  Grants one requester at a time, latches its request and drives exactly one memory strobe.
//  Returns read data with a one-cycle done pulse. Sits between the core's fetch/LSU and the memory.
// PARAMETERS
//  RESET_PRIO  0   port that wins the first simultaneous contention after reset (0 or 1)
//  PERF_W      32  width of performance counters (used only with MEM_ARB_PERF_EN)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  pN_req       in   1   port N (N=0,1) requests an access; held until pN_done
//  pN_we        in   1   1 = write, 0 = read; sampled at grant
//  pN_addr      in   32  byte address; sampled at grant
//  pN_wdata     in   32  write data; sampled at grant
//  pN_wmask     in   4   byte-lane write enables; sampled at grant
//  pN_rdata     out  32  read data; equals mem_rdata, valid only while pN_done=1 on a read
//  pN_done      out  1   one-cycle completion pulse for port N
//  mem_addr     out  32  to memory: latched address
//  mem_wdata    out  32  to memory: latched write data
//  mem_wmask    out  4   to memory: latched mask
//  mem_wstrobe  out  1   to memory: write strobe, one cycle per write
//  mem_rstrobe  out  1   to memory: read strobe, one cycle per read
//  mem_rdata    in   32  from memory: registered read data, valid the cycle after rstrobe
//  mem_done     in   1   from memory: access complete
// BEHAVIOUR
//  Reset (async, immediate):
//   state=IDLE; all strobes, pN_done and mem_* outputs 0; last_grant=~RESET_PRIO.
//  FSM states: IDLE, ACCESS, RESP.
//   IDLE: if any pN_req, pick the winner, latch its we/addr/wdata/wmask and grant id -> ACCESS. Else stay.
//   ACCESS: mem_rstrobe=~we_q or mem_wstrobe=we_q for exactly this cycle; mem_addr/wdata/wmask driven from latches -> RESP.
//   RESP: strobes 0. If mem_done: pulse pN_done for the granted port, update last_grant=grant -> IDLE. Else hold in RESP.
//  Arbitration:
//   Only one requester -> it wins.
//   Both requesting -> the port != last_grant wins (strict alternation under contention).
//  Latency: req seen in cycle T (IDLE) -> strobe in T+1 -> done in T+2 (mem_done=1). Back-to-back throughput is one access per 3 cycles.
//  Requester drops req in the cycle after done; a req still high in IDLE starts a new access.
//  req deasserted before done: the in-flight access still completes and done still pulses. A request is never cancelled.
//  A port's input changes after grant are ignored until its next grant.
//  pN_done never asserts for both ports in the same cycle. A non-granted port sees pN_done=0.
//  mem_addr/wdata/wmask hold their last value outside ACCESS; mem_wstrobe and mem_rstrobe are never both 1.
//  Reset mid-ACCESS or mid-RESP: access abandoned, no done pulse, memory write may or may not have occurred.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined adds outputs perf_grant0, perf_grant1, perf_conflict [PERF_W-1:0]:
//   perf_grantN increments when port N completes (pN_done).
//   perf_conflict increments each IDLE cycle in which both req are high.
//   Counters reset to 0 and wrap at 2^PERF_W.
//  MEM_ARB_PERF_EN undefined: no counter logic and no perf ports; arbitration unchanged.
// TESTING
//  1. Reset, p0 read addr 0x10 (mem word4=0xDEADBEEF):
//     mem_rstrobe at T+1 with mem_addr=0x10; p0_done at T+2 with p0_rdata=0xDEADBEEF.
//  2. p1 write addr 0x20 data 0x11223344 mask 4'b0101, then p1 read 0x20:
//     reads back with only bytes 0 and 2 updated (0x..22..44 merge); p1_done once per access.
//  3. p0 and p1 req together from reset, RESET_PRIO=0, held for 4 accesses each:
//     grants alternate 0,1,0,1...; no cycle with both done.
//  4. p0 changes addr 0x10 -> 0x30 in the ACCESS cycle:
//     mem_addr stays 0x10 and the returned data is from 0x10.
//  5. rst_n low during ACCESS:
//     strobes drop immediately, no done pulse; FSM in IDLE after release, next req served normally.
//  6. MEM_ARB_PERF_EN, 3 contended pairs plus 2 solo p0:
//     perf_grant0=5, perf_grant1=3, perf_conflict>=3.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a shared single-port word memory.
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a request; picks winner and latches its fields
// S_ACCESS | one-cycle read or write strobe to memory from the latches
// S_RESP   | waiting for mem_done; pulses done for the granted port
module mem_arbiter #(
    parameter int RESET_PRIO = 0,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [3:0]        p0_wmask,
    output logic [31:0]       p0_rdata,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [3:0]        p1_wmask,
    output logic [31:0]       p1_rdata,
    output logic              p1_done,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic              mem_wstrobe,
    output logic              mem_rstrobe,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_done
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_grant0,
    output logic [PERF_W-1:0] perf_grant1,
    output logic [PERF_W-1:0] perf_conflict
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // last_grant starts as the loser so RESET_PRIO wins the first contention
    localparam logic LP_LAST_RST = (RESET_PRIO == 0);

    if (PERF_W < 1 || RESET_PRIO < 0 || RESET_PRIO > 1) begin : g_bad_param
        $error("mem_arbiter: RESET_PRIO must be 0 or 1 and PERF_W >= 1");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic        w_pick;
    logic        w_latch;
    logic        w_complete;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_complete  = 1'b0;
        w_pick      = (p0_req & p1_req) ? ~r_last_grant : p1_req;
        case (r_state)
            S_IDLE: begin
                if (p0_req | p1_req) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP: begin
                if (mem_done) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= LP_LAST_RST;
        end else begin
            r_state <= w_state_nxt;
            if (w_complete) begin
                r_last_grant <= r_grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_latch) begin
            r_grant <= w_pick;
            r_we    <= w_pick ? p1_we    : p0_we;
            r_addr  <= w_pick ? p1_addr  : p0_addr;
            r_wdata <= w_pick ? p1_wdata : p0_wdata;
            r_wmask <= w_pick ? p1_wmask : p0_wmask;
        end
    end

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_wmask   = r_wmask;
    assign mem_rstrobe = (r_state == S_ACCESS) & ~r_we;
    assign mem_wstrobe = (r_state == S_ACCESS) &  r_we;

    assign p0_done  = w_complete & ~r_grant;
    assign p1_done  = w_complete &  r_grant;
    assign p0_rdata = mem_rdata;
    assign p1_rdata = mem_rdata;

`ifdef MEM_ARB_PERF_EN
    localparam logic [PERF_W-1:0] LP_ONE = 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (p0_done) begin
                perf_grant0 <= perf_grant0 + LP_ONE;
            end
            if (p1_done) begin
                perf_grant1 <= perf_grant1 + LP_ONE;
            end
            if (r_state == S_IDLE && p0_req && p1_req) begin
                perf_conflict <= perf_conflict + LP_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_wmask, p1_wmask;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_done, p1_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        mem_wstrobe, mem_rstrobe, mem_done;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.RESET_PRIO(0), .PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wmask(p0_wmask), .p0_rdata(p0_rdata), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wmask(p1_wmask), .p1_rdata(p1_rdata), .p1_done(p1_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_wstrobe(mem_wstrobe), .mem_rstrobe(mem_rstrobe),
        .mem_rdata(mem_rdata), .mem_done(mem_done)
`ifdef MEM_ARB_PERF_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
        .perf_conflict(perf_conflict)
`endif
    );

    // Memory model: registered read data, done after mem_lat extra cycles.
    logic [31:0] mem [256];
    bit          init_done = 1'b0;
    int          mem_lat   = 0;
    logic        pend;
    int          cnt;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= {8'hA5, 16'h0000, i[7:0]};
            mem[4]    <= 32'hDEADBEEF;
            mem[8]    <= 32'hAABBCCDD;
            mem[12]   <= 32'h30303030;
            init_done <= 1'b1;
        end else begin
            if (mem_rstrobe) mem_rdata <= mem[mem_addr[9:2]];
            if (mem_wstrobe) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else if (mem_rstrobe || mem_wstrobe) begin
            pend <= 1'b1;
            cnt  <= mem_lat;
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
    end
    assign mem_done = pend && (cnt == 0);

    typedef struct {
        int          port;
        bit          rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic push(input int p, input bit rd, input logic [31:0] d);
        exp_t e;
        e.port = p; e.rd = rd; e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int p, input logic [31:0] rdata);
        exp_t e;
        chk("sb_has_entry", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_port", p, e.port);
            if (e.rd) chk("rdata", rdata, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (p0_done || p1_done) chk("single_done", p0_done & p1_done, 0);
        if (mem_rstrobe || mem_wstrobe) chk("single_strobe", mem_rstrobe & mem_wstrobe, 0);
        if (p0_done) pop_check(0, p0_rdata);
        if (p1_done) pop_check(1, p1_rdata);
    end

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wmask);
        if (p == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_wmask = wmask;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_wmask = wmask;
        end
    endtask

    task automatic wait_done(input int p);
        bit got = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            got = (p == 0) ? p0_done : p1_done;
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    // Call at #1 after a rising edge; returns at the same phase.
    task automatic run_port(input int p, input int n, input logic we, input logic [31:0] addr0,
                            input logic [31:0] wdata, input logic [3:0] wmask);
        for (int k = 0; k < n; k++) begin
            set_port(p, 1'b1, we, addr0 + 32'(4 * k), wdata, wmask);
            wait_done(p);
            @(posedge clk); #1;
        end
        set_port(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rstrobe", mem_rstrobe, 0);
        chk("rst_wstrobe", mem_wstrobe, 0);
        chk("rst_p0_done", p0_done, 0);
        chk("rst_p1_done", p1_done, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single p0 read: strobe at T+1, done at T+2
        @(posedge clk); #1;
        push(0, 1, 32'hDEADBEEF);
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_idle_rstrobe", mem_rstrobe, 0);
        @(negedge clk);
        chk("t1_rstrobe", mem_rstrobe, 1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        @(negedge clk);
        chk("t1_p0_done", p0_done, 1);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Address change after grant is ignored
        @(posedge clk); #1;
        push(0, 1, 32'hDEADBEEF);
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(posedge clk); #1;
        p0_addr = 32'h30;
        @(negedge clk);
        chk("t4_mem_addr_held", mem_addr, 32'h10);
        wait_done(0);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Masked write then readback: bytes 0 and 2 replaced
        @(posedge clk); #1;
        push(1, 0, 32'h0);
        run_port(1, 1, 1'b1, 32'h20, 32'h11223344, 4'b0101);
        push(1, 1, 32'hAA22CC44);
        run_port(1, 1, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("t2_mem_addr_hold", mem_addr, 32'h20);

        // Slow memory: arbiter holds in RESP until mem_done
        mem_lat = 2;
        push(0, 1, 32'hA5000014);
        set_port(0, 1'b1, 1'b0, 32'h50, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("slow_no_early_done", p0_done, 0);
        @(negedge clk);
        chk("slow_still_waiting", p0_done, 0);
        @(negedge clk);
        chk("slow_done", p0_done, 1);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_lat = 0;

        // Reset during ACCESS: strobe drops at once, no done, next access normal
        @(posedge clk); #1;
        set_port(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t5_rstrobe_before", mem_rstrobe, 1);
        #1 rst_n = 1'b0;
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("t5_rstrobe_async", mem_rstrobe, 0);
        chk("t5_wstrobe_async", mem_wstrobe, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        push(1, 1, 32'hAA22CC44);
        run_port(1, 1, 1'b0, 32'h20, 32'h0, 4'h0);

        // Contention from reset: strict alternation 0,1,0,1,...
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(0, 1, 32'hA5000010 + 32'(k));
            push(1, 1, 32'hA5000020 + 32'(k));
        end
        fork
            run_port(0, 4, 1'b0, 32'h40, 32'h0, 4'h0);
            run_port(1, 4, 1'b0, 32'h80, 32'h0, 4'h0);
        join

`ifdef MEM_ARB_PERF_EN
        do_reset();
        chk("perf_rst_g0", perf_grant0, 0);
        for (int k = 0; k < 3; k++) begin
            push(0, 1, 32'hA5000010 + 32'(k));
            push(1, 1, 32'hA5000020 + 32'(k));
        end
        push(0, 1, 32'hA5000013);
        push(0, 1, 32'hA5000014);
        fork
            run_port(0, 3, 1'b0, 32'h40, 32'h0, 4'h0);
            run_port(1, 3, 1'b0, 32'h80, 32'h0, 4'h0);
        join
        run_port(0, 2, 1'b0, 32'h4C, 32'h0, 4'h0);
        chk("perf_grant0", perf_grant0, 5);
        chk("perf_grant1", perf_grant1, 3);
        chk("perf_conflict_ge3", (perf_conflict >= 3), 1);
`endif

        for (int c = 0; c < 32 && sb.size() > 0; c++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
